// File: rtl/microc_ctrl.sv
// microc_ctrl: control unit for the microc datapath.
// Decodes the opcode and zero flag into datapath controls, and sequences
// execution through run / single-step / halt. It also keeps a debug count of
// executed instructions.
module microc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_abs,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op,
  output logic             pc_en,
  output logic             step_ack,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_SWAIT = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           state_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] icount_q;
  logic [CNT_W-1:0] icount_d;

  logic is_alu, is_li, is_j, is_jz, is_jnz, is_jr, is_nop, is_halt;
  logic is_legal, active, exec_en, take_jump;

  // Classify the opcode and work out whether an instruction executes this cycle
  always_comb begin
    is_alu    = opcode[5];
    is_li     = (opcode[5:2] == 4'b0100);
    is_j      = (opcode == 6'b000000);
    is_jz     = (opcode == 6'b000001);
    is_jnz    = (opcode == 6'b000010);
    is_jr     = (opcode == 6'b000011);
    is_nop    = (opcode == 6'b000100);
    is_halt   = (opcode == 6'b000111);
    is_legal  = is_alu | is_li | is_j | is_jz | is_jnz | is_jr | is_nop | is_halt;
    active    = (state_q == S_RUN) || (state_q == S_STEP);
    // HALT and undefined opcodes never execute; they only end the sequence
    exec_en   = active && is_legal && !is_halt;
    take_jump = is_j | is_jr | (is_jz & z) | (is_jnz & ~z);
    icount_d  = icount_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Drive datapath controls; idle values unless a legal instruction executes
  always_comb begin
    s_inc = 1'b1;
    s_abs = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    op    = 3'b000;
    pc_en = 1'b0;
    if (exec_en) begin
      pc_en = 1'b1;
      if (take_jump) s_inc = 1'b0;
      if (is_jr)     s_abs = 1'b0;
      if (is_alu) begin
        op  = opcode[4:2];
        we3 = 1'b1;
        wez = 1'b1;
      end
      if (is_li) begin
        s_inm = 1'b1;
        we3   = 1'b1;
      end
    end
  end

  // Sequencer: state, sticky flags and the executed-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      if (exec_en) icount_q <= icount_d;
      case (state_q)
        S_IDLE: begin
          if (run)           state_q <= S_RUN;
          else if (step_req) state_q <= S_STEP;
        end
        S_RUN: begin
          if (is_halt || !is_legal) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= !is_legal;
          end else if (!run) begin
            state_q <= S_IDLE;
          end
        end
        S_STEP: begin
          if (is_halt || !is_legal) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= !is_legal;
          end else begin
            state_q <= S_SWAIT;
          end
        end
        // A held step request must be released before another step is taken
        S_SWAIT: begin
          if (!step_req) state_q <= S_IDLE;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign step_ack = (state_q == S_STEP);
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign icount   = icount_q;

endmodule

// File: tb/tb_microc_ctrl.sv
// Testbench for microc_ctrl: directed scenarios plus randomized stimulus,
// compared against a behavioural model of the control unit.
module tb_microc_ctrl;

  logic       clk = 1'b0;
  logic       reset, run, step_req, z;
  logic [5:0] opcode;

  logic        s_inc, s_abs, s_inm, we3, wez, pc_en, step_ack, halted, illegal;
  logic [2:0]  op;
  logic [15:0] icount;

  logic        s_inc4, s_abs4, s_inm4, we34, wez4, pc_en4, step_ack4, halted4, illegal4;
  logic [2:0]  op4;
  logic [3:0]  icount4;

  always #5 clk = ~clk;

  microc_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .opcode(opcode), .z(z),
    .s_inc(s_inc), .s_abs(s_abs), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
    .pc_en(pc_en), .step_ack(step_ack), .halted(halted), .illegal(illegal), .icount(icount)
  );

  microc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .opcode(opcode), .z(z),
    .s_inc(s_inc4), .s_abs(s_abs4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .op(op4),
    .pc_en(pc_en4), .step_ack(step_ack4), .halted(halted4), .illegal(illegal4), .icount(icount4)
  );

  localparam logic [5:0] OP_LI   = 6'b010000;
  localparam logic [5:0] OP_SUB  = 6'b101100;
  localparam logic [5:0] OP_J    = 6'b000000;
  localparam logic [5:0] OP_JZ   = 6'b000001;
  localparam logic [5:0] OP_JNZ  = 6'b000010;
  localparam logic [5:0] OP_JR   = 6'b000011;
  localparam logic [5:0] OP_NOP  = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b000111;
  localparam logic [5:0] OP_BAD  = 6'b000101;

  // Model modes
  localparam int MI = 0, MR = 1, MS = 2, MW = 3, MH = 4;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_seen = 0;
  int          m_mode = MI;
  logic        m_halted = 1'b0;
  logic        m_illegal = 1'b0;
  int unsigned m_icnt = 0;

  // Small program + datapath used to close the loop for the program scenario
  bit          use_prog = 1'b0;
  int          pc;
  logic [7:0]  rg [2];
  logic        zf;
  logic [5:0]  prog_op  [5] = '{OP_LI, OP_LI, OP_SUB, OP_JNZ, OP_HALT};
  logic [7:0]  prog_imm [5] = '{8'd5, 8'd1, 8'd0, 8'd2, 8'd0};
  int          prog_dst [5] = '{0, 1, 0, 0, 0};

  wire [8:0] ctl  = {s_inc, s_abs, s_inm, we3, wez, op, pc_en};
  wire [8:0] ctl4 = {s_inc4, s_abs4, s_inm4, we34, wez4, op4, pc_en4};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // 0 = executes, 1 = HALT, 2 = undefined
  function automatic int kind(input logic [5:0] o);
    casez (o)
      6'b1?????, 6'b0100??:                               return 0;
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100: return 0;
      6'b000111:                                          return 1;
      default:                                            return 2;
    endcase
  endfunction

  // Expected {s_inc,s_abs,s_inm,we3,wez,op,pc_en} from the decode table
  function automatic logic [8:0] exp_ctl(input bit act, input logic [5:0] o, input logic zz);
    logic [8:0] idle = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    if (!act) return idle;
    casez (o)
      6'b1?????:  return {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, o[4:2], 1'b1};
      6'b0100??:  return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1};
      6'b000000:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
      6'b000001:  return {!zz,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
      6'b000010:  return {zz,   1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
      6'b000011:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
      6'b000100:  return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
      default:    return idle;
    endcase
  endfunction

  function automatic bit m_active();
    return (m_mode == MR) || (m_mode == MS);
  endfunction

  task automatic check_all();
    logic [8:0] ex;
    ex = exp_ctl(m_active(), opcode, z);
    chk("ctl", 32'(ctl), 32'(ex));
    chk("ctl4", 32'(ctl4), 32'(ex));
    chk("step_ack", 32'(step_ack), 32'(m_mode == MS));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("illegal", 32'(illegal), 32'(m_illegal));
    chk("icount", 32'(icount), m_icnt & 32'hFFFF);
    chk("icount4", 32'(icount4), m_icnt & 32'hF);
  endtask

  task automatic model_step();
    int k;
    k = kind(opcode);
    if (!reset) begin
      m_mode = MI; m_halted = 1'b0; m_illegal = 1'b0; m_icnt = 0;
    end else begin
      case (m_mode)
        MI: m_mode = run ? MR : (step_req ? MS : MI);
        MR, MS: begin
          if (k == 0) m_icnt++;
          if (k != 0) begin
            m_mode = MH; m_halted = 1'b1; m_illegal = (k == 2);
          end else if (m_mode == MS) m_mode = MW;
          else if (!run) m_mode = MI;
        end
        MW: if (!step_req) m_mode = MI;
        default: ;
      endcase
    end
  endtask

  task automatic dp_update(input logic [8:0] ex);
    logic [7:0] res;
    if (pc < 0 || pc > 4) return;
    if (ex[5]) begin
      if (ex[6]) rg[prog_dst[pc]] = prog_imm[pc];
      else begin
        res = rg[0] - rg[1];
        rg[0] = res;
        if (ex[4]) zf = (res == 8'd0);
      end
    end
    if (ex[0]) begin
      if (ex[8]) pc = pc + 1;
      else if (ex[7]) pc = int'(prog_imm[pc]);
      else pc = pc + int'(prog_imm[pc]);
    end
  endtask

  task automatic tick();
    logic [8:0] ex;
    @(negedge clk);
    check_all();
    if (step_ack === 1'b1) ack_seen++;
    @(posedge clk);
    ex = exp_ctl(m_active(), opcode, z);
    if (use_prog) dp_update(ex);
    model_step();
    #1;
    if (use_prog && pc >= 0 && pc <= 4) begin
      opcode = prog_op[pc];
      z = zf;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; step_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(0, 31);
    if (r == 0) return {3'b001, 3'($urandom)};
    if (r == 1) return OP_HALT;
    case ($urandom_range(0, 2))
      0:       return {1'b1, 5'($urandom)};
      1:       return {4'b0100, 2'($urandom)};
      default: return 6'($urandom_range(0, 4));
    endcase
  endfunction

  logic [5:0] jseq [6] = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_JR, OP_J};
  logic       zseq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b0; run = 1'b0; step_req = 1'b0; opcode = OP_NOP; z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state and idle outputs
    check_all();

    // Countdown program: LI 5; LI 1; SUB; JNZ 2; HALT
    do_reset();
    pc = 0; rg[0] = 8'd0; rg[1] = 8'd0; zf = 1'b0;
    use_prog = 1'b1; opcode = prog_op[0]; z = 1'b0; run = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (m_halted) break;
    end
    tick();
    use_prog = 1'b0;
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_icount", 32'(icount), 32'd12);

    // Single step held for four cycles, then a second step
    do_reset();
    opcode = OP_LI; z = 1'b0; step_req = 1'b1; ack_seen = 0;
    repeat (4) tick();
    step_req = 1'b0;
    repeat (2) tick();
    chk("step_once", 32'(ack_seen), 32'd1);
    chk("step_icount", 32'(icount), 32'd1);
    step_req = 1'b1; tick();
    step_req = 1'b0; tick();
    chk("step_again", 32'(ack_seen), 32'd2);
    chk("step_icount2", 32'(icount), 32'd2);

    // Undefined opcode while running
    do_reset();
    run = 1'b1; opcode = OP_NOP;
    repeat (2) tick();
    opcode = OP_BAD; tick();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_icount", 32'(icount), 32'd1);
    opcode = OP_NOP;
    for (int i = 0; i < 4; i++) begin run = i[0]; tick(); end
    chk("ill_absorb", 32'(icount), 32'd1);

    // Conditional and relative jumps
    do_reset();
    run = 1'b1; opcode = OP_NOP; tick();
    for (int i = 0; i < 6; i++) begin opcode = jseq[i]; z = zseq[i]; tick(); end

    // run and step_req together from IDLE
    do_reset();
    run = 1'b1; step_req = 1'b1; opcode = OP_NOP; ack_seen = 0;
    repeat (3) tick();
    chk("runstep_noack", 32'(ack_seen), 32'd0);

    // Reset in the middle of running
    do_reset();
    run = 1'b1; opcode = OP_NOP;
    repeat (3) tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    chk("midrst_icount", 32'(icount), 32'd0);
    chk("midrst_pc_en", 32'(pc_en), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    run = 1'b0; tick();

    // 17 NOPs wrap the 4-bit counter to 1
    do_reset();
    run = 1'b1; opcode = OP_NOP;
    repeat (18) tick();
    chk("wrap4", 32'(icount4), 32'd1);
    chk("wrap16", 32'(icount), 32'd17);

    // Randomized stimulus
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_mode == MH) reset = ($urandom_range(0, 7) != 0);
      else              reset = ($urandom_range(0, 99) != 0);
      run      = ($urandom_range(0, 3) != 0) ? run : !run;
      step_req = ($urandom_range(0, 2) == 0) ? !step_req : step_req;
      opcode   = rand_op();
      z        = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
